parametros_secuenciador: RTL and testbench
==========================================

# parametros_secuenciador

Sequencer that drives the parameter-memory decoder through its address range: it walks `addr` from 0 to `N_PARAM-1` under user step commands, then presents the terminal address `N_PARAM` and waits for the decoder's ready flag (`listo_ht`). It sits between the user-input debouncers and the parameter memory, and owns `addr`/`en` exclusively. It reports completion, abort and optional timeout to the top-level control.

## Interface
Parameters:
- `N_PARAM`, 9: number of editable parameters; terminal address equals `N_PARAM`.
- `AW`, 4: address width; must satisfy `N_PARAM < 2**AW`.
- `TIMEOUT`, 1000000: idle cycles per address before abort; used only with `SEQ_TIMEOUT_EN`.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `iniciar` input 1: start a sequence; honoured only in IDLE.
- `avanzar` input 1: confirm the current parameter and step forward.
- `retroceder` input 1: step back one address.
- `cancelar` input 1: abort to IDLE from any non-IDLE state.
- `listo_ht` input 1: ready flag from the parameter memory at the terminal address.
- `addr` output AW: address to the parameter memory.
- `en` output 1: memory enable.
- `ocupado` output 1: high in any state other than IDLE.
- `hecho` output 1: one-cycle completion pulse.
- `error` output 1: one-cycle abort pulse (timeout only); constant 0 without `SEQ_TIMEOUT_EN`.

## Operation
- FSM states: IDLE, EDITA, FIN.
- IDLE
  - `addr`=0, `en`=0, `ocupado`=0.
  - `iniciar`=1 -> EDITA with `addr`=0.
- EDITA
  - `en`=1, `ocupado`=1; the memory decodes `addr` to its one-hot enable.
  - `avanzar`: `addr`+1. If `addr`==`N_PARAM-1`, `addr` becomes `N_PARAM` and the FSM moves to FIN.
  - `retroceder`: `addr`-1, saturating at 0 (stays in EDITA).
- FIN
  - `addr`=`N_PARAM`, `en`=1.
  - `retroceder`: `addr`=`N_PARAM-1`, back to EDITA.
  - `avanzar`: ignored.
  - `listo_ht`=1 -> IDLE with `hecho`=1 for one cycle.
- Input priority each cycle: `cancelar` > timeout > (`avanzar` XOR `retroceder`).
  - `avanzar` and `retroceder` both high in the same cycle: neither is acted on.
- `cancelar` in EDITA or FIN -> IDLE next cycle, `addr`=0, `hecho`=0, `error`=0.
- `iniciar` outside IDLE: ignored. `avanzar`, `retroceder` and `cancelar` in IDLE: ignored.
- Step inputs are level-sampled every cycle. Upstream delivers single-cycle pulses; a held level steps once per cycle.
- `addr` never exceeds `N_PARAM`. No wrap-around in either direction.

## Timing
- Reset (`rst`=1 at an edge):
  - State IDLE; `addr`=0, `en`=0, `ocupado`=0, `hecho`=0, `error`=0; timeout counter cleared.
  - Reset has priority over all inputs, including mid-sequence.
- All outputs are registered. Every command takes effect at the edge where it is sampled; outputs change 1 cycle after the input is seen.
- `iniciar` sampled at edge k: `en`=1, `addr`=0 from k+1.
- `listo_ht` sampled high in FIN at edge k: `hecho`=1 and `en`=0 during cycle k+1 only.
- Minimum full sequence: 1 (`iniciar`) + `N_PARAM` (`avanzar` pulses) + 1 (`listo_ht`) cycles.

## Configuration
- Macro `SEQ_TIMEOUT_EN`.
- Defined:
  - A counter clears on entering EDITA or FIN, on every accepted step, and in IDLE.
  - It increments every cycle otherwise.
  - On reaching `TIMEOUT-1` with no accepted step -> IDLE, `error`=1 for one cycle, `addr`=0.
  - `cancelar` in the same cycle wins: `error` stays 0.
- Not defined:
  - No counter logic is present and `error` is tied to 0.
  - The FSM waits indefinitely in EDITA and FIN.

## Structure
- Package `parametros_pkg` holds:
  - the state enum (IDLE, EDITA, FIN);
  - `N_PARAM` and `AW` defaults;
  - the reset values of the outputs.
- One sub-module, `sec_watchdog`: timeout counter with `clr`/`expira` ports.
  - Instantiated only under `SEQ_TIMEOUT_EN`.
  - Counter width is `$clog2(TIMEOUT)`.

## Test plan
- Reset mid-EDITA at `addr`=5 -> next cycle `addr`=0, `en`=0, `ocupado`=0, all pulses 0.
- `iniciar`, then 9 `avanzar` pulses, then `listo_ht`=1 -> `addr` runs 0..9, `en`=1 throughout; single `hecho` pulse; back to IDLE.
- At `addr`=0, `retroceder` -> `addr` stays 0. At `addr`=3, `avanzar`+`retroceder` together -> `addr` stays 3. In FIN, `retroceder` -> `addr`=8, state EDITA.
- `cancelar` at `addr`=7 together with `avanzar` -> IDLE, `addr`=0, `hecho`=0.
- With `SEQ_TIMEOUT_EN` and `TIMEOUT`=16: no input for 16 cycles at `addr`=2 -> `error` pulses once, IDLE. An `avanzar` at cycle 15 -> no error, `addr`=3, counter restarts.
- `iniciar` in EDITA and `listo_ht`=1 in EDITA -> ignored, with no change to `addr` or pulses.

Source files
------------

// File: rtl/parametros_secuenciador_pkg.sv
// Shared types and defaults for the parameter-memory sequencer.
// Timeout supervision is compiled in only when SEQ_TIMEOUT_EN is defined.
package parametros_pkg;

  localparam int N_PARAM_DEF = 9;
  localparam int AW_DEF      = 4;

  typedef enum logic [1:0] {
    IDLE,
    EDITA,
    FIN
  } estado_e;

  // Output values held while rst is asserted
  localparam int   ADDR_RST    = 0;
  localparam logic EN_RST      = 1'b0;
  localparam logic OCUPADO_RST = 1'b0;
  localparam logic HECHO_RST   = 1'b0;
  localparam logic ERROR_RST   = 1'b0;

endpackage

// File: rtl/parametros_secuenciador_if.sv
// Command/status bundle between the user-input side and the sequencer.
// The slave modport is the sequencer's view.
interface parametros_secuenciador_if
  import parametros_pkg::*;
#(
  parameter int AW = AW_DEF
);
  logic          iniciar;
  logic          avanzar;
  logic          retroceder;
  logic          cancelar;
  logic          listo_ht;
  logic [AW-1:0] addr;
  logic          en;
  logic          ocupado;
  logic          hecho;
  logic          error;

  modport master (
    output iniciar, avanzar, retroceder, cancelar, listo_ht,
    input  addr, en, ocupado, hecho, error
  );

  modport slave (
    input  iniciar, avanzar, retroceder, cancelar, listo_ht,
    output addr, en, ocupado, hecho, error
  );
endinterface

// File: rtl/sec_watchdog.sv
// Idle-cycle counter: clears on clr, otherwise counts up and holds at TIMEOUT-1,
// where expira is asserted.
module sec_watchdog #(
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic expira
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (!expira)
      cnt <= cnt + CW'(1);
  end

  assign expira = (cnt == ULTIMO);
endmodule

// File: rtl/parametros_secuenciador.sv
// Walks the parameter-memory address 0..N_PARAM-1 under user steps, then waits at
// N_PARAM for listo_ht. Optional idle timeout enabled by macro SEQ_TIMEOUT_EN.
module parametros_secuenciador
  import parametros_pkg::*;
#(
  parameter int N_PARAM = N_PARAM_DEF,
  parameter int AW      = AW_DEF,
  parameter int TIMEOUT = 1000000
) (
  input logic                     clk,
  input logic                     rst,
  parametros_secuenciador_if.slave bus
);
  localparam logic [AW-1:0] A_ULT  = AW'(N_PARAM - 1);
  localparam logic [AW-1:0] A_TERM = AW'(N_PARAM);

  estado_e       st, st_n;
  logic [AW-1:0] addr_r, addr_n;
  logic          en_r, ocupado_r, hecho_r, error_r;
  logic          hecho_n, error_n;
  logic          paso, expira;
  logic          avz, ret;

  // Both step inputs high cancel each other out
  assign avz = bus.avanzar & ~bus.retroceder;
  assign ret = bus.retroceder & ~bus.avanzar;

`ifdef SEQ_TIMEOUT_EN
  sec_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    ((st == IDLE) || paso),
    .expira (expira)
  );
`else
  logic unused_timeout;
  assign expira         = 1'b0;
  assign unused_timeout = ^{TIMEOUT, paso};
`endif

  always_comb begin
    st_n    = st;
    addr_n  = addr_r;
    hecho_n = 1'b0;
    error_n = 1'b0;
    paso    = 1'b0;
    unique case (st)
      IDLE: begin
        addr_n = '0;
        if (bus.iniciar) st_n = EDITA;
      end
      EDITA: begin
        if (bus.cancelar) begin
          st_n   = IDLE;
          addr_n = '0;
        end else if (expira) begin
          st_n    = IDLE;
          addr_n  = '0;
          error_n = 1'b1;
        end else if (avz) begin
          paso   = 1'b1;
          addr_n = addr_r + AW'(1);
          if (addr_r == A_ULT) st_n = FIN;
        end else if (ret) begin
          paso = 1'b1;
          if (addr_r != '0) addr_n = addr_r - AW'(1);
        end
      end
      FIN: begin
        if (bus.cancelar) begin
          st_n   = IDLE;
          addr_n = '0;
        end else if (expira) begin
          st_n    = IDLE;
          addr_n  = '0;
          error_n = 1'b1;
        end else if (ret) begin
          paso   = 1'b1;
          st_n   = EDITA;
          addr_n = A_ULT;
        end else if (bus.listo_ht) begin
          st_n    = IDLE;
          addr_n  = '0;
          hecho_n = 1'b1;
        end else begin
          addr_n = A_TERM;
        end
      end
      default: begin
        st_n   = IDLE;
        addr_n = '0;
      end
    endcase
  end

  // Registered state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      addr_r    <= AW'(ADDR_RST);
      en_r      <= EN_RST;
      ocupado_r <= OCUPADO_RST;
      hecho_r   <= HECHO_RST;
      error_r   <= ERROR_RST;
    end else begin
      st        <= st_n;
      addr_r    <= addr_n;
      en_r      <= (st_n != IDLE);
      ocupado_r <= (st_n != IDLE);
      hecho_r   <= hecho_n;
      error_r   <= error_n;
    end
  end

  assign bus.addr    = addr_r;
  assign bus.en      = en_r;
  assign bus.ocupado = ocupado_r;
  assign bus.hecho   = hecho_r;
  assign bus.error   = error_r;
endmodule

// File: tb/tb_parametros_secuenciador.sv
// Bench for parametros_secuenciador: directed vector table, timeout sequences
// (when SEQ_TIMEOUT_EN is defined) and random stimulus against a reference model.
module tb_parametros_secuenciador;
  localparam int N  = 9;
  localparam int AW = 4;
`ifdef SEQ_TIMEOUT_EN
  localparam int TO    = 16;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 1000000;
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parametros_secuenciador_if #(.AW(AW)) bus ();

  parametros_secuenciador #(.N_PARAM(N), .AW(AW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, i, a, b, c, l);
    rst            = r;
    bus.iniciar    = i;
    bus.avanzar    = a;
    bus.retroceder = b;
    bus.cancelar   = c;
    bus.listo_ht   = l;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic r, i, a, b, c, l;
    int   e_addr;
    logic e_en, e_ocu, e_hecho;
  } vec_t;

  function automatic vec_t v(input logic r, i, a, b, c, l,
                             input int ea, input logic een, eoc, eh);
    vec_t x;
    x.r = r; x.i = i; x.a = a; x.b = b; x.c = c; x.l = l;
    x.e_addr = ea; x.e_en = een; x.e_ocu = eoc; x.e_hecho = eh;
    return x;
  endfunction

  // Reference model: busy flag plus address; the wait-for-ready phase is addr==N
  bit m_busy;
  int m_a, m_idle;
  bit m_h, m_e;

  task automatic model_step(input logic r, i, a, b, c, l);
    bit stepped;
    stepped = 1'b0;
    m_h = 1'b0;
    m_e = 1'b0;
    if (r) begin
      m_busy = 1'b0; m_a = 0; m_idle = 0;
    end else if (!m_busy) begin
      if (i) m_busy = 1'b1;
      m_a = 0; m_idle = 0;
    end else begin
      if (c) begin
        m_busy = 1'b0; m_a = 0;
      end else if (TO_EN && m_idle == TO - 1) begin
        m_busy = 1'b0; m_a = 0; m_e = 1'b1;
      end else if (b && !a) begin
        stepped = 1'b1;
        if (m_a > 0) m_a = m_a - 1;
      end else if (a && !b && m_a < N) begin
        stepped = 1'b1;
        m_a = m_a + 1;
      end else if (m_a == N && l) begin
        m_busy = 1'b0; m_a = 0; m_h = 1'b1;
      end
      m_idle = stepped ? 0 : m_idle + 1;
    end
  endtask

  vec_t tbl[$];

  initial begin
    // rst ini av rt can listo | addr en ocu hecho
    tbl.push_back(v(1,0,0,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0, 0,1,1,0));
    tbl.push_back(v(0,0,0,1,0,0, 0,1,1,0));
    tbl.push_back(v(0,0,1,0,0,0, 1,1,1,0));
    tbl.push_back(v(0,0,1,0,0,0, 2,1,1,0));
    tbl.push_back(v(0,0,1,0,0,0, 3,1,1,0));
    tbl.push_back(v(0,0,1,1,0,0, 3,1,1,0));
    tbl.push_back(v(0,1,0,0,0,0, 3,1,1,0));
    tbl.push_back(v(0,0,0,0,0,1, 3,1,1,0));
    tbl.push_back(v(0,0,1,0,0,0, 4,1,1,0));
    tbl.push_back(v(0,0,1,0,0,0, 5,1,1,0));
    tbl.push_back(v(1,0,1,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0, 0,1,1,0));
    for (int k = 1; k <= N; k++) tbl.push_back(v(0,0,1,0,0,0, k,1,1,0));
    tbl.push_back(v(0,0,1,0,0,0, N,1,1,0));
    tbl.push_back(v(0,0,0,1,0,0, N-1,1,1,0));
    tbl.push_back(v(0,0,1,0,0,0, N,1,1,0));
    tbl.push_back(v(0,0,0,0,0,1, 0,0,0,1));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0, 0,1,1,0));
    for (int k = 1; k <= 7; k++) tbl.push_back(v(0,0,1,0,0,0, k,1,1,0));
    tbl.push_back(v(0,0,1,0,1,0, 0,0,0,0));
    tbl.push_back(v(0,0,1,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,0,0,1,0,0, 0,0,0,0));
    tbl.push_back(v(0,0,0,0,1,0, 0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,1, 0,0,0,0));

    rst = 1'b1;
    bus.iniciar = 1'b0; bus.avanzar = 1'b0; bus.retroceder = 1'b0;
    bus.cancelar = 1'b0; bus.listo_ht = 1'b0;
    @(posedge clk);
    #1;

    foreach (tbl[n]) begin
      drive(tbl[n].r, tbl[n].i, tbl[n].a, tbl[n].b, tbl[n].c, tbl[n].l);
      chk($sformatf("vec%0d_addr", n), int'(bus.addr), tbl[n].e_addr);
      chk($sformatf("vec%0d_en", n), int'(bus.en), int'(tbl[n].e_en));
      chk($sformatf("vec%0d_ocupado", n), int'(bus.ocupado), int'(tbl[n].e_ocu));
      chk($sformatf("vec%0d_hecho", n), int'(bus.hecho), int'(tbl[n].e_hecho));
      chk($sformatf("vec%0d_error", n), int'(bus.error), 0);
    end

`ifdef SEQ_TIMEOUT_EN
    // Silence for TIMEOUT cycles at addr 2 aborts with a single error pulse
    drive(1,0,0,0,0,0);
    drive(0,1,0,0,0,0);
    drive(0,0,1,0,0,0);
    drive(0,0,1,0,0,0);
    for (int k = 1; k <= TO - 1; k++) begin
      drive(0,0,0,0,0,0);
      chk($sformatf("to_wait%0d_error", k), int'(bus.error), 0);
      chk($sformatf("to_wait%0d_addr", k), int'(bus.addr), 2);
    end
    drive(0,0,0,0,0,0);
    chk("to_fire_error", int'(bus.error), 1);
    chk("to_fire_addr", int'(bus.addr), 0);
    chk("to_fire_en", int'(bus.en), 0);
    drive(0,0,0,0,0,0);
    chk("to_after_error", int'(bus.error), 0);

    // A step on the last quiet cycle restarts the count
    drive(0,1,0,0,0,0);
    drive(0,0,1,0,0,0);
    drive(0,0,1,0,0,0);
    for (int k = 1; k <= TO - 2; k++) drive(0,0,0,0,0,0);
    drive(0,0,1,0,0,0);
    chk("to_save_error", int'(bus.error), 0);
    chk("to_save_addr", int'(bus.addr), 3);
    for (int k = 1; k <= TO - 1; k++) drive(0,0,0,0,0,0);
    chk("to_restart_quiet", int'(bus.error), 0);
    drive(0,0,0,0,0,0);
    chk("to_restart_fire", int'(bus.error), 1);

    // Cancel on the expiry cycle wins over the timeout
    drive(0,1,0,0,0,0);
    for (int k = 1; k <= TO - 1; k++) drive(0,0,0,0,0,0);
    drive(0,0,0,0,1,0);
    chk("to_cancel_error", int'(bus.error), 0);
    chk("to_cancel_ocupado", int'(bus.ocupado), 0);
`endif

    // Random stimulus, alternating busy and quiet phases
    for (int n = 0; n < 3000; n++) begin
      logic r, i, a, b, c, l;
      bit quiet;
      quiet = ((n / 250) % 2) == 1;
      r = (n == 0) || ($urandom_range(0, 199) == 0);
      i = ($urandom_range(0, 3) == 0);
      l = ($urandom_range(0, 3) == 0);
      if (quiet) begin
        a = ($urandom_range(0, 39) == 0);
        b = ($urandom_range(0, 59) == 0);
        c = ($urandom_range(0, 199) == 0);
      end else begin
        a = ($urandom_range(0, 2) == 0);
        b = ($urandom_range(0, 5) == 0);
        c = ($urandom_range(0, 29) == 0);
      end
      model_step(r, i, a, b, c, l);
      drive(r, i, a, b, c, l);
      chk("rnd_addr", int'(bus.addr), m_a);
      chk("rnd_en", int'(bus.en), int'(m_busy));
      chk("rnd_ocupado", int'(bus.ocupado), int'(m_busy));
      chk("rnd_hecho", int'(bus.hecho), int'(m_h));
      chk("rnd_error", int'(bus.error), int'(m_e));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
